// File: rtl/video_mnist_frame_scheduler.sv
// Frame admission controller in front of the MNIST LUT-CNN core: frame skipping and
// in-flight credit limiting on a zero-latency AXI4-Stream pass-through.
module video_mnist_frame_scheduler #(
    parameter int unsigned TUSER_WIDTH  = 1,
    parameter int unsigned TDATA_WIDTH  = 1,
    parameter int unsigned IMG_Y_WIDTH  = 10,
    parameter int unsigned SKIP_WIDTH   = 4,
    parameter int unsigned CREDIT_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    param_enable,
    input  logic [SKIP_WIDTH-1:0]   param_skip,
    input  logic [IMG_Y_WIDTH-1:0]  param_height,
    input  logic [CREDIT_WIDTH-1:0] param_max_inflight,

    input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]  s_axi4s_tdata,
    input  logic                    s_axi4s_tvalid,
    output logic                    s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]  m_axi4s_tuser,
    output logic                    m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]  m_axi4s_tdata,
    output logic                    m_axi4s_tvalid,
    input  logic                    m_axi4s_tready,

    input  logic                    mon_tuser0,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,

    output logic [CREDIT_WIDTH-1:0] status_inflight,
    output logic [15:0]             status_pass_count,
    output logic [15:0]             status_drop_count,
    output logic                    status_err
);

    typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

    state_e                  state_q, state_d;
    logic [IMG_Y_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [SKIP_WIDTH-1:0]   skip_left_q, skip_left_d;
    logic [CREDIT_WIDTH-1:0] inflight_q, inflight_d;
    logic [15:0]             pass_count_q, pass_count_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic                    err_q, err_d;

    logic                    sof, early, decide, credit_ok, skip_ok, take;
    logic                    beat_hs, credit_inc, credit_dec;
    state_e                  frame_st;
    logic [IMG_Y_WIDTH-1:0]  height_eff, line_base;
    logic [IMG_Y_WIDTH:0]    line_inc;

    assign m_axi4s_tuser = s_axi4s_tuser;
    assign m_axi4s_tlast = s_axi4s_tlast;
    assign m_axi4s_tdata = s_axi4s_tdata;

    assign status_inflight   = inflight_q;
    assign status_pass_count = pass_count_q;
    assign status_drop_count = drop_count_q;
    assign status_err        = err_q;

    // Decision and gating: a SOF beat that is being decided already takes on
    // the state of the frame it opens, so it is forwarded or dropped that cycle.
    always_comb begin
        sof        = s_axi4s_tvalid & s_axi4s_tuser[0];
        early      = sof & (state_q != StIdle) & (line_cnt_q != '0);
        decide     = sof & ((state_q == StIdle) | early);
        credit_ok  = inflight_q < param_max_inflight;
        // Down-counter of frames still to skip; 0 means the next frame is taken,
        // so the first frame after reset passes.
        skip_ok    = (skip_left_q == '0);
        take       = param_enable & credit_ok & skip_ok;
        frame_st   = decide ? (take ? StPass : StDrop) : state_q;

        m_axi4s_tvalid = (frame_st == StPass) ? s_axi4s_tvalid : 1'b0;
        s_axi4s_tready = (frame_st == StPass) ? m_axi4s_tready : 1'b1;

        beat_hs    = s_axi4s_tvalid & s_axi4s_tready;
        height_eff = (param_height == '0) ? IMG_Y_WIDTH'(1) : param_height;
        line_base  = decide ? '0 : line_cnt_q;
        line_inc   = {1'b0, line_base} + 1'b1;
        credit_inc = decide & beat_hs & take;
        credit_dec = mon_tuser0 & mon_tvalid & mon_tready;
    end

    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        skip_left_d  = skip_left_q;
        inflight_d   = inflight_q;
        pass_count_d = pass_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q | early;

        if (beat_hs && (frame_st != StIdle)) begin
            state_d    = frame_st;
            line_cnt_d = line_base;
            if (s_axi4s_tlast) begin
                // Height is compared live so a shrinking height still ends the frame.
                if (line_inc >= {1'b0, height_eff}) begin
                    state_d    = StIdle;
                    line_cnt_d = '0;
                end else begin
                    line_cnt_d = line_inc[IMG_Y_WIDTH-1:0];
                end
            end
        end

        if (decide && beat_hs) begin
            if (take) begin
                skip_left_d  = param_skip;
                pass_count_d = pass_count_q + 16'd1;
            end else begin
                drop_count_d = drop_count_q + 16'd1;
                if (param_enable && credit_ok && !skip_ok) begin
                    skip_left_d = skip_left_q - 1'b1;
                end
            end
        end

        if (credit_inc && !credit_dec) begin
            inflight_d = inflight_q + 1'b1;
        end else if (credit_dec && !credit_inc) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            line_cnt_q   <= '0;
            skip_left_q  <= '0;
            inflight_q   <= '0;
            pass_count_q <= '0;
            drop_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            skip_left_q  <= skip_left_d;
            inflight_q   <= inflight_d;
            pass_count_q <= pass_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_video_mnist_frame_scheduler.sv
// Scoreboard bench for video_mnist_frame_scheduler: 4-line x 8-pixel frames,
// forwarded beats queued at source handshake and checked at the core port.
module tb_video_mnist_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        param_enable;
    logic [3:0]  param_skip;
    logic [9:0]  param_height;
    logic [1:0]  param_max_inflight;
    logic [0:0]  s_axi4s_tuser;
    logic        s_axi4s_tlast;
    logic [0:0]  s_axi4s_tdata;
    logic        s_axi4s_tvalid;
    logic        s_axi4s_tready;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast;
    logic [0:0]  m_axi4s_tdata;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready;
    logic        mon_tuser0;
    logic        mon_tvalid;
    logic        mon_tready;
    logic [1:0]  status_inflight;
    logic [15:0] status_pass_count;
    logic [15:0] status_drop_count;
    logic        status_err;

    int tests = 0;
    int fails = 0;
    int popped = 0;
    logic [2:0] sb[$];
    bit rand_ready = 0;
    bit check_ready = 0;
    bit mon_on_sof = 0;

    always #5 clk = ~clk;

    video_mnist_frame_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .param_enable       (param_enable),
        .param_skip         (param_skip),
        .param_height       (param_height),
        .param_max_inflight (param_max_inflight),
        .s_axi4s_tuser      (s_axi4s_tuser),
        .s_axi4s_tlast      (s_axi4s_tlast),
        .s_axi4s_tdata      (s_axi4s_tdata),
        .s_axi4s_tvalid     (s_axi4s_tvalid),
        .s_axi4s_tready     (s_axi4s_tready),
        .m_axi4s_tuser      (m_axi4s_tuser),
        .m_axi4s_tlast      (m_axi4s_tlast),
        .m_axi4s_tdata      (m_axi4s_tdata),
        .m_axi4s_tvalid     (m_axi4s_tvalid),
        .m_axi4s_tready     (m_axi4s_tready),
        .mon_tuser0         (mon_tuser0),
        .mon_tvalid         (mon_tvalid),
        .mon_tready         (mon_tready),
        .status_inflight    (status_inflight),
        .status_pass_count  (status_pass_count),
        .status_drop_count  (status_drop_count),
        .status_err         (status_err)
    );

    task automatic drive_beat(input logic sof, input logic last, input bit exp_fwd);
        bit done = 0;
        int guard = 0;
        logic [2:0] exp;
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = sof;
        s_axi4s_tlast  = last;
        s_axi4s_tdata  = 1'($urandom);
        if (sof && mon_on_sof) begin
            mon_tuser0 = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
        end
        while (!done) begin
            m_axi4s_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (exp_fwd && check_ready) begin
                tests++;
                if (s_axi4s_tready !== m_axi4s_tready) begin
                    fails++;
                    $display("FAIL ready_follow: s_tready=%b required %b", s_axi4s_tready, m_axi4s_tready);
                end
            end
            if (!exp_fwd) begin
                tests++;
                if (m_axi4s_tvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL fwd_in_drop: m_tvalid=%b required 0", m_axi4s_tvalid);
                end
            end
            if (s_axi4s_tready === 1'b1) begin
                if (exp_fwd) sb.push_back({sof, last, s_axi4s_tdata});
                done = 1;
            end
            if (m_axi4s_tvalid === 1'b1 && m_axi4s_tready === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %b%b%b required none",
                             m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata);
                end else begin
                    exp = sb.pop_front();
                    popped++;
                    if ({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== exp) begin
                        fails++;
                        $display("FAIL beat_data: got %b%b%b required %b", m_axi4s_tuser,
                                 m_axi4s_tlast, m_axi4s_tdata, exp);
                    end
                end
            end
            @(posedge clk);
            #1;
            mon_tuser0 = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
            guard++;
            if (!done && guard >= 200) begin
                tests++; fails++;
                $display("FAIL handshake_timeout: no s handshake within %0d cycles", guard);
                done = 1;
            end
        end
        s_axi4s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit exp_fwd, input int first_b, input int end_b);
        for (int b = first_b; b < end_b; b++) drive_beat(b == 0, (b % 8) == 7, exp_fwd);
        @(posedge clk);
        #1;
    endtask

    task automatic mon_pulse();
        mon_tuser0 = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
        @(posedge clk);
        #1;
        mon_tuser0 = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axi4s_tvalid = 1'b0;
        mon_tuser0 = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        popped = 0;
    endtask

    task automatic test_reset();
        param_enable = 1'b1; param_skip = 4'd0; param_height = 10'd4; param_max_inflight = 2'd3;
        s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = 1'b1; m_axi4s_tready = 1'b1;
        do_reset();
        s_axi4s_tvalid = 1'b1;
        @(negedge clk);
        tests++; if (m_axi4s_tvalid !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid: got %b required 0", m_axi4s_tvalid); end
        tests++; if (s_axi4s_tready !== 1'b1) begin fails++; $display("FAIL rst_s_tready: got %b required 1", s_axi4s_tready); end
        tests++; if (status_inflight !== 2'd0) begin fails++; $display("FAIL rst_inflight: got %0d required 0", status_inflight); end
        tests++; if (status_pass_count !== 16'd0 || status_drop_count !== 16'd0) begin
            fails++; $display("FAIL rst_counts: got %0d/%0d required 0/0", status_pass_count, status_drop_count); end
        tests++; if (status_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", status_err); end
        @(posedge clk);
        #1;
        s_axi4s_tvalid = 1'b0;
    endtask

    task automatic test_pass_all();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_frame(1, 0, 32);
            mon_pulse();
        end
        @(negedge clk);
        tests++; if (popped != 96 || sb.size() != 0) begin fails++; $display("FAIL pass_all_beats: got %0d left %0d required 96 left 0", popped, sb.size()); end
        tests++; if (status_pass_count !== 16'd3) begin fails++; $display("FAIL pass_all_pass: got %0d required 3", status_pass_count); end
        tests++; if (status_drop_count !== 16'd0) begin fails++; $display("FAIL pass_all_drop: got %0d required 0", status_drop_count); end
        tests++; if (status_inflight !== 2'd0) begin fails++; $display("FAIL pass_all_inflight: got %0d required 0", status_inflight); end
    endtask

    task automatic test_skip();
        do_reset();
        param_skip = 4'd2;
        for (int f = 0; f < 9; f++) begin
            send_frame((f % 3) == 0, 0, 32);
            if ((f % 3) == 0) mon_pulse();
        end
        @(negedge clk);
        tests++; if (popped != 96 || sb.size() != 0) begin fails++; $display("FAIL skip_beats: got %0d left %0d required 96 left 0", popped, sb.size()); end
        tests++; if (status_pass_count !== 16'd3) begin fails++; $display("FAIL skip_pass: got %0d required 3", status_pass_count); end
        tests++; if (status_drop_count !== 16'd6) begin fails++; $display("FAIL skip_drop: got %0d required 6", status_drop_count); end
        param_skip = 4'd0;
    endtask

    task automatic test_credit();
        do_reset();
        param_max_inflight = 2'd1;
        send_frame(1, 0, 32);
        send_frame(0, 0, 32);
        send_frame(0, 0, 32);
        @(negedge clk);
        tests++; if (status_inflight !== 2'd1) begin fails++; $display("FAIL credit_inflight: got %0d required 1", status_inflight); end
        tests++; if (status_pass_count !== 16'd1 || status_drop_count !== 16'd2) begin
            fails++; $display("FAIL credit_counts: got %0d/%0d required 1/2", status_pass_count, status_drop_count); end
        @(posedge clk);
        #1;
        mon_pulse();
        @(negedge clk);
        tests++; if (status_inflight !== 2'd0) begin fails++; $display("FAIL credit_return: got %0d required 0", status_inflight); end
        tests++; if (status_err !== 1'b0) begin fails++; $display("FAIL credit_err_early: got %b required 0", status_err); end
        @(posedge clk);
        #1;
        send_frame(1, 0, 32);
        mon_pulse();
        mon_pulse();
        @(negedge clk);
        tests++; if (popped != 64 || status_pass_count !== 16'd2) begin
            fails++; $display("FAIL credit_resume: got %0d beats pass %0d required 64 pass 2", popped, status_pass_count); end
        tests++; if (status_err !== 1'b1 || status_inflight !== 2'd0) begin
            fails++; $display("FAIL credit_underflow: got err %b inflight %0d required 1 0", status_err, status_inflight); end
        param_max_inflight = 2'd3;
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_ready = 1; check_ready = 1;
        send_frame(1, 0, 32);
        mon_pulse();
        send_frame(1, 0, 32);
        mon_pulse();
        rand_ready = 0; check_ready = 0;
        @(negedge clk);
        tests++; if (popped != 64 || sb.size() != 0) begin fails++; $display("FAIL bp_beats: got %0d left %0d required 64 left 0", popped, sb.size()); end
        tests++; if (status_pass_count !== 16'd2 || status_inflight !== 2'd0) begin
            fails++; $display("FAIL bp_status: got pass %0d inflight %0d required 2 0", status_pass_count, status_inflight); end
    endtask

    task automatic test_early_sof();
        do_reset();
        send_frame(1, 0, 16);
        @(negedge clk);
        tests++; if (status_err !== 1'b0) begin fails++; $display("FAIL early_err_before: got %b required 0", status_err); end
        @(posedge clk);
        #1;
        mon_on_sof = 1;
        send_frame(1, 0, 32);
        mon_on_sof = 0;
        @(negedge clk);
        tests++; if (status_err !== 1'b1) begin fails++; $display("FAIL early_err: got %b required 1", status_err); end
        tests++; if (status_inflight !== 2'd1) begin fails++; $display("FAIL early_inflight: got %0d required 1", status_inflight); end
        tests++; if (popped != 48 || status_pass_count !== 16'd2) begin
            fails++; $display("FAIL early_pass: got %0d beats pass %0d required 48 pass 2", popped, status_pass_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(1, 0, 16);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
        @(negedge clk);
        tests++; if (m_axi4s_tvalid !== 1'b0 || s_axi4s_tready !== 1'b1) begin
            fails++; $display("FAIL rstmid_outputs: got tvalid %b tready %b required 0 1", m_axi4s_tvalid, s_axi4s_tready); end
        tests++; if (status_inflight !== 2'd0 || status_pass_count !== 16'd0) begin
            fails++; $display("FAIL rstmid_status: got inflight %0d pass %0d required 0 0", status_inflight, status_pass_count); end
        @(posedge clk);
        #1;
        s_axi4s_tvalid = 1'b0;
        send_frame(0, 16, 32);
        send_frame(1, 0, 32);
        @(negedge clk);
        tests++; if (popped != 48 || sb.size() != 0 || status_pass_count !== 16'd1) begin
            fails++; $display("FAIL rstmid_next: got %0d beats pass %0d required 48 pass 1", popped, status_pass_count); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mon_tuser0 = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
        s_axi4s_tvalid = 1'b0;
        test_reset();
        test_pass_all();
        test_skip();
        test_credit();
        test_backpressure();
        test_early_sof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
